// File: rtl/rf_arb_pkg.sv
// Shared widths and the write-request record for the register-file write-port arbiter.
package rf_arb_pkg;

   localparam int REG_W    = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   typedef struct packed {
      logic [REG_W-1:0]  addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Long-latency result FIFO: DEPTH entries of {addr, data}, pointers carry an extra wrap bit
// so full and empty are distinguishable. Synchronous active-low reset empties it.
module rf_arb_fifo
   import rf_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push_i,
   input  wb_req_t push_data_i,
   input  logic    pop_i,
   output logic    full_o,
   output logic    empty_o,
   output wb_req_t head_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_req_t        mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q;
   logic [AW:0]    rd_ptr_q;

   // Pointer update; the caller never pushes when full nor pops when empty.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage array, written at the write pointer.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered LL results,
// tracks pending LL destinations and stalls issue. Optional same-cycle LL bypass: RF_ARB_BYPASS_EN.
module rf_wb_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iss_valid,
   input  logic              iss_ll,
   input  logic [REG_W-1:0]  iss_rs,
   input  logic [REG_W-1:0]  iss_rt,
   input  logic [REG_W-1:0]  iss_rd,
   output logic              iss_stall,
   input  logic              p_wr,
   input  logic [REG_W-1:0]  p_addr,
   input  logic [DATA_W-1:0] p_data,
   output logic              p_hold,
   input  logic              ll_valid,
   input  logic [REG_W-1:0]  ll_addr,
   input  logic [DATA_W-1:0] ll_data,
   output logic              ll_ready,
   output logic              rf_wr,
   output logic [REG_W-1:0]  rf_addr,
   output logic [DATA_W-1:0] rf_data
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CRED_FULL = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [NUM_REGS-1:1] sb_q, sb_d;
   logic [CW-1:0]       cred_q, cred_d;
   logic [SW-1:0]       starve_q, starve_d;
   logic [NUM_REGS-1:0] sb_s;

   logic    fifo_full_s, fifo_empty_s, push_s, pop_s;
   wb_req_t head_s, push_data_s;
   logic    p_req_s, h_req_s, head_zero_s, grant_f_s, bypass_s;
   logic    hazard_s, accept_s, cred_inc_s, cred_dec_s;

   rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push_s),
      .push_data_i (push_data_s),
      .pop_i       (pop_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s),
      .head_o      (head_s)
   );

   assign sb_s        = {sb_q, 1'b0};
   assign p_req_s     = p_wr && (p_addr != '0);
   assign h_req_s     = !fifo_empty_s && (head_s.addr != '0);
   assign head_zero_s = !fifo_empty_s && (head_s.addr == '0);
   assign grant_f_s   = reset && h_req_s && (!p_req_s || (starve_q == STARVE_LIM));

`ifdef RF_ARB_BYPASS_EN
   assign bypass_s    = reset && fifo_empty_s && !p_req_s && ll_valid;
`else
   assign bypass_s    = 1'b0;
`endif

   // Zero-address heads carry no write and drain regardless of arbitration.
   assign pop_s       = grant_f_s || (reset && head_zero_s);
   assign ll_ready    = reset && !fifo_full_s;
   assign push_s      = ll_valid && ll_ready && !bypass_s;
   assign push_data_s = '{addr: ll_addr, data: ll_data};

   assign hazard_s    = sb_s[iss_rs] | sb_s[iss_rt] | sb_s[iss_rd] |
                        (iss_ll && (cred_q == CRED_FULL));
   assign iss_stall   = !reset || (iss_valid && hazard_s);
   assign accept_s    = reset && iss_valid && !hazard_s;
   assign cred_inc_s  = accept_s && iss_ll;
   assign cred_dec_s  = pop_s || bypass_s;

   // Write-port mux: FIFO head, then pipeline, then (optionally) the bypassed LL result.
   always_comb begin
      rf_wr   = 1'b0;
      rf_addr = '0;
      rf_data = '0;
      p_hold  = 1'b0;
      if (grant_f_s) begin
         rf_wr   = 1'b1;
         rf_addr = head_s.addr;
         rf_data = head_s.data;
         p_hold  = p_req_s;
      end else if (reset && p_req_s) begin
         rf_wr   = 1'b1;
         rf_addr = p_addr;
         rf_data = p_data;
      end else if (bypass_s && (ll_addr != '0)) begin
         rf_wr   = 1'b1;
         rf_addr = ll_addr;
         rf_data = ll_data;
      end else begin
         rf_wr   = 1'b0;
      end
   end

   // Scoreboard, credit and starvation next state; an issue-set beats a same-cycle commit-clear.
   always_comb begin
      logic [NUM_REGS-1:0] sb_n;
      sb_n = sb_s;
      if (grant_f_s) begin
         sb_n[head_s.addr] = 1'b0;
      end else begin
         sb_n = sb_n;
      end
      if (bypass_s) begin
         sb_n[ll_addr] = 1'b0;
      end else begin
         sb_n = sb_n;
      end
      if (cred_inc_s) begin
         sb_n[iss_rd] = 1'b1;
      end else begin
         sb_n = sb_n;
      end
      sb_d = sb_n[NUM_REGS-1:1];

      case ({cred_inc_s, cred_dec_s})
         2'b10:   cred_d = cred_q + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   cred_d = cred_q - {{(CW-1){1'b0}}, 1'b1};
         default: cred_d = cred_q;
      endcase

      if (fifo_empty_s || grant_f_s) begin
         starve_d = '0;
      end else if (h_req_s && (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
      end else begin
         starve_d = starve_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sb_q     <= '0;
         cred_q   <= '0;
         starve_q <= '0;
      end else begin
         sb_q     <= sb_d;
         cred_q   <= cred_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with sporadic resets.
module tb_rf_wb_arbiter;
   import rf_arb_pkg::*;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        iss_valid = 1'b0, iss_ll = 1'b0;
   logic [4:0]  iss_rs = 5'd0, iss_rt = 5'd0, iss_rd = 5'd0;
   logic        iss_stall;
   logic        p_wr = 1'b0;
   logic [4:0]  p_addr = 5'd0;
   logic [31:0] p_data = 32'd0;
   logic        p_hold;
   logic        ll_valid = 1'b0;
   logic [4:0]  ll_addr = 5'd0;
   logic [31:0] ll_data = 32'd0;
   logic        ll_ready;
   logic        rf_wr;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .iss_valid(iss_valid), .iss_ll(iss_ll), .iss_rs(iss_rs), .iss_rt(iss_rt),
      .iss_rd(iss_rd), .iss_stall(iss_stall),
      .p_wr(p_wr), .p_addr(p_addr), .p_data(p_data), .p_hold(p_hold),
      .ll_valid(ll_valid), .ll_addr(ll_addr), .ll_data(ll_data), .ll_ready(ll_ready),
      .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: scoreboard as a bit array, FIFO as a queue, counters as ints.
   bit      m_sb [32];
   wb_req_t m_q [$];
   int      m_cred = 0;
   int      m_starve = 0;
   int      pend [$];

   bit          e_stall, e_hold, e_ready, e_wr;
   bit [4:0]    e_addr;
   bit [31:0]   e_data;
   bit          e_pop, e_push, e_bypass, e_accept, e_grant, e_hreq, e_empty;

   function automatic void eval_model();
      bit preq, hazard, full;
      e_stall = 1'b1; e_hold = 1'b0; e_ready = 1'b0; e_wr = 1'b0;
      e_addr = 5'd0; e_data = 32'd0;
      e_pop = 1'b0; e_push = 1'b0; e_bypass = 1'b0; e_accept = 1'b0; e_grant = 1'b0;
      e_empty = (m_q.size() == 0);
      e_hreq = !e_empty && (m_q[0].addr != 5'd0);
      if (reset === 1'b1) begin
         full     = (m_q.size() == DEPTH);
         hazard   = m_sb[iss_rs] || m_sb[iss_rt] || m_sb[iss_rd] || (iss_ll && m_cred == DEPTH);
         e_stall  = iss_valid && hazard;
         e_accept = iss_valid && !hazard;
         e_ready  = !full;
         preq     = p_wr && (p_addr != 5'd0);
         e_grant  = e_hreq && (!preq || m_starve == STARVE_MAX);
         e_pop    = e_grant || (!e_empty && m_q[0].addr == 5'd0);
`ifdef RF_ARB_BYPASS_EN
         e_bypass = e_empty && !preq && ll_valid;
`endif
         e_push   = ll_valid && !full && !e_bypass;
         if (e_grant) begin
            e_wr = 1'b1; e_addr = m_q[0].addr; e_data = m_q[0].data; e_hold = preq;
         end else if (preq) begin
            e_wr = 1'b1; e_addr = p_addr; e_data = p_data;
         end else if (e_bypass && ll_addr != 5'd0) begin
            e_wr = 1'b1; e_addr = ll_addr; e_data = ll_data;
         end
      end
   endfunction

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      eval_model();
      chk1("iss_stall", iss_stall, e_stall);
      chk1("p_hold", p_hold, e_hold);
      chk1("ll_ready", ll_ready, e_ready);
      chk1("rf_wr", rf_wr, e_wr);
      if (e_wr) begin
         chk32("rf_addr", 32'(rf_addr), 32'(e_addr));
         chk32("rf_data", rf_data, e_data);
      end
   end

   // Model state advance on the rising edge, including the LL unit's outstanding list.
   always @(posedge clk) begin
      eval_model();
      if (reset !== 1'b1) begin
         foreach (m_sb[i]) m_sb[i] = 1'b0;
         m_q.delete();
         pend.delete();
         m_cred = 0;
         m_starve = 0;
      end else begin
         if (e_grant) m_sb[m_q[0].addr] = 1'b0;
         if (e_bypass) m_sb[ll_addr] = 1'b0;
         if (e_accept && iss_ll && iss_rd != 5'd0) m_sb[iss_rd] = 1'b1;
         if (e_empty || e_grant) m_starve = 0;
         else if (e_hreq && m_starve < STARVE_MAX) m_starve++;
         m_cred = m_cred + ((e_accept && iss_ll) ? 1 : 0) - ((e_pop || e_bypass) ? 1 : 0);
         if (e_pop) void'(m_q.pop_front());
         if (e_push) m_q.push_back('{addr: ll_addr, data: ll_data});
         if ((e_push || e_bypass) && pend.size() > 0) void'(pend.pop_front());
         if (e_accept && iss_ll) pend.push_back(int'(iss_rd));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_valid = 1'b0; iss_ll = 1'b0; iss_rs = 5'd0; iss_rt = 5'd0; iss_rd = 5'd0;
      p_wr = 1'b0; p_addr = 5'd0; p_data = 32'd0;
      ll_valid = 1'b0; ll_addr = 5'd0; ll_data = 32'd0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic issue_ll(input logic [4:0] rd);
      iss_valid = 1'b1; iss_ll = 1'b1; iss_rd = rd; iss_rs = 5'd0; iss_rt = 5'd0;
   endtask

   initial begin
      idle();
      #2;
      chk1("rst_iss_stall", iss_stall, 1'b1);
      chk1("rst_rf_wr", rf_wr, 1'b0);
      chk1("rst_ll_ready", ll_ready, 1'b0);
      chk1("rst_p_hold", p_hold, 1'b0);

`ifndef RF_ARB_BYPASS_EN
      // RAW stall on a pending LL destination.
      do_reset();
      issue_ll(5'd5);
      #1 chk1("a_ll_accept", iss_stall, 1'b0);
      tick();
      iss_ll = 1'b0; iss_rs = 5'd5; iss_rd = 5'd6;
      #1 chk1("a_raw_stall", iss_stall, 1'b1);
      tick();
      ll_valid = 1'b1; ll_addr = 5'd5; ll_data = 32'h0000_5555;
      #1 chk1("a_stall_on_push", iss_stall, 1'b1);
      tick();
      ll_valid = 1'b0;
      #1;
      chk1("a_commit_wr", rf_wr, 1'b1);
      chk32("a_commit_addr", 32'(rf_addr), 32'd5);
      chk1("a_stall_commit_cycle", iss_stall, 1'b1);
      tick();
      #1 chk1("a_stall_drops", iss_stall, 1'b0);
      tick();

      // Starvation: queued r7 wins on the fifth cycle against continuous r3 writes.
      do_reset();
      issue_ll(5'd7);
      tick();
      idle();
      p_wr = 1'b1; p_addr = 5'd3; p_data = 32'h0000_0033;
      ll_valid = 1'b1; ll_addr = 5'd7; ll_data = 32'h0000_0077;
      tick();
      ll_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk32("b_pipe_addr", 32'(rf_addr), 32'd3);
         chk1("b_pipe_nohold", p_hold, 1'b0);
         tick();
      end
      #1;
      chk32("b_forced_addr", 32'(rf_addr), 32'd7);
      chk32("b_forced_data", rf_data, 32'h0000_0077);
      chk1("b_forced_hold", p_hold, 1'b1);
      tick();
      #1;
      chk1("b_r3_wr", rf_wr, 1'b1);
      chk32("b_r3_addr", 32'(rf_addr), 32'd3);
      chk1("b_r3_nohold", p_hold, 1'b0);
      tick();

      // Credit exhaustion with DEPTH=2.
      do_reset();
      issue_ll(5'd1);
      tick();
      issue_ll(5'd2);
      tick();
      issue_ll(5'd3);
      #1 chk1("c_cred_stall", iss_stall, 1'b1);
      ll_valid = 1'b1; ll_addr = 5'd1; ll_data = 32'h0000_0011;
      tick();
      ll_valid = 1'b0;
      #1;
      chk1("c_stall_pop_cycle", iss_stall, 1'b1);
      chk32("c_pop_addr", 32'(rf_addr), 32'd1);
      tick();
      #1 chk1("c_accept_after_pop", iss_stall, 1'b0);
      tick();

      // Full FIFO refuses pushes until the cycle after a pop.
      do_reset();
      issue_ll(5'd1);
      tick();
      issue_ll(5'd2);
      tick();
      idle();
      p_wr = 1'b1; p_addr = 5'd9; p_data = 32'h0000_0099;
      ll_valid = 1'b1; ll_addr = 5'd1; ll_data = 32'h0000_0011;
      tick();
      ll_addr = 5'd2; ll_data = 32'h0000_0022;
      #1 chk1("d_ready_one_entry", ll_ready, 1'b1);
      tick();
      ll_addr = 5'd3; ll_data = 32'h0000_0033;
      for (int i = 0; i < 3; i++) begin
         #1 chk1("d_full_not_ready", ll_ready, 1'b0);
         tick();
      end
      #1;
      chk1("d_ready_pop_cycle", ll_ready, 1'b0);
      chk32("d_head_intact_addr", 32'(rf_addr), 32'd1);
      chk32("d_head_intact_data", rf_data, 32'h0000_0011);
      chk1("d_head_hold", p_hold, 1'b1);
      tick();
      #1 chk1("d_ready_after_pop", ll_ready, 1'b1);
      tick();
      #1 chk1("d_push_taken", ll_ready, 1'b0);
      tick();

      // Address-0 head drains alongside a pipeline write.
      do_reset();
      issue_ll(5'd0);
      tick();
      idle();
      p_wr = 1'b1; p_addr = 5'd9; p_data = 32'hDEAD_BEEF;
      ll_valid = 1'b1; ll_addr = 5'd0; ll_data = 32'h0000_0000;
      tick();
      ll_valid = 1'b0;
      #1;
      chk1("e_r9_wr", rf_wr, 1'b1);
      chk32("e_r9_addr", 32'(rf_addr), 32'd9);
      chk32("e_r9_data", rf_data, 32'hDEAD_BEEF);
      chk1("e_nohold", p_hold, 1'b0);
      tick();
      p_wr = 1'b0;
      issue_ll(5'd1);
      #1 chk1("e_first_ll", iss_stall, 1'b0);
      tick();
      issue_ll(5'd2);
      #1 chk1("e_cred_decremented", iss_stall, 1'b0);
      tick();
`endif

      // Reset mid-operation with two queued results and r4 pending.
      do_reset();
      issue_ll(5'd4);
      tick();
      issue_ll(5'd5);
      tick();
      idle();
      p_wr = 1'b1; p_addr = 5'd9; p_data = 32'h0000_0099;
      ll_valid = 1'b1; ll_addr = 5'd4; ll_data = 32'h0000_0044;
      tick();
      ll_addr = 5'd5; ll_data = 32'h0000_0055;
      tick();
      ll_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk1("f_rst_rf_wr", rf_wr, 1'b0);
      chk1("f_rst_stall", iss_stall, 1'b1);
      chk1("f_rst_ready", ll_ready, 1'b0);
      chk1("f_rst_hold", p_hold, 1'b0);
      tick();
      reset = 1'b1;
      p_wr = 1'b0;
      iss_valid = 1'b1; iss_ll = 1'b0; iss_rs = 5'd4; iss_rt = 5'd0; iss_rd = 5'd10;
      #1;
      chk1("f_r4_not_stalled", iss_stall, 1'b0);
      chk1("f_fifo_empty", rf_wr, 1'b0);
      tick();

      // Randomized traffic; the LL unit only returns results for accepted LL issues.
      do_reset();
      repeat (3000) begin
         reset     = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         iss_valid = 1'($urandom_range(0, 1));
         iss_ll    = 1'($urandom_range(0, 1));
         iss_rs    = 5'($urandom_range(0, 7));
         iss_rt    = 5'($urandom_range(0, 7));
         iss_rd    = 5'($urandom_range(0, 7));
         p_wr      = 1'($urandom_range(0, 1));
         p_addr    = 5'($urandom_range(0, 7));
         p_data    = $urandom;
         if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
            ll_valid = 1'b1;
            ll_addr  = 5'(pend[0]);
            ll_data  = $urandom;
         end else begin
            ll_valid = 1'b0;
            ll_addr  = 5'($urandom_range(0, 31));
            ll_data  = $urandom;
         end
         tick();
      end
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writers: the in-order pipeline writeback and a long-latency (LL) unit (mul/div, slow loads).
- Buffers LL results in a small FIFO.
- Keeps a per-register scoreboard of pending LL writes and tells issue when to stall on RAW/WAW hazards or on credit exhaustion.
- Sits between the WB stage, the LL unit and the register file; drives the register file's wr/addr3/data3.

Parameters:
- DEPTH, 2: LL result FIFO entries; power of 2, at least 2.
- STARVE_MAX, 4: number of consecutive cycles the FIFO head may lose arbitration before it is force-granted.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset; clock clk
- iss_valid  in  1  instruction present at issue
- iss_ll  in  1  issuing instruction is LL
- iss_rs  in  5  source register 1
- iss_rt  in  5  source register 2
- iss_rd  in  5  destination register
- iss_stall  out  1  issue must hold
- p_wr  in  1  pipeline WB write request
- p_addr  in  5  pipeline WB destination
- p_data  in  32  pipeline WB data
- p_hold  out  1  WB lost the port this cycle; pipeline freezes and re-presents next cycle
- ll_valid  in  1  LL result valid
- ll_addr  in  5  LL result destination
- ll_data  in  32  LL result data
- ll_ready  out  1  FIFO can accept
- rf_wr  out  1  register file write enable
- rf_addr  out  5  register file write address
- rf_data  out  32  register file write data

Behaviour:
- State:
  - sb[31:1]: scoreboard; sb[0] is constant 0.
  - FIFO with DEPTH entries of {addr, data}.
  - cred: outstanding LL count, 0..DEPTH.
  - starve: starvation counter, 0..STARVE_MAX.
- Reset (reset=0):
  - State: sb cleared, FIFO emptied, cred=0, starve=0.
  - Outputs while reset is low: rf_wr=0, p_hold=0, ll_ready=0, iss_stall=1.
  - Reset mid-operation discards all buffered results and pending marks; no writes are issued.
- Issue:
  - iss_stall = iss_valid && (sb[iss_rs] | sb[iss_rt] | sb[iss_rd] | (iss_ll && cred==DEPTH)). This is combinational.
  - Accept = iss_valid && !iss_stall.
  - On accept with iss_ll: cred increments, and sb[iss_rd] is set if iss_rd != 0.
- LL push:
  - ll_ready = !full. This is conservative: no push when full, even if a pop happens in the same cycle.
  - A pushed entry is never written in the same cycle; its earliest write is the next cycle.
- Arbitration (combinational; rf_* have zero latency):
  - p_req = p_wr && p_addr != 0.
  - h_req = FIFO non-empty && head.addr != 0.
  - Head with addr 0: popped immediately in any cycle, concurrently with any pipeline write, with no rf_wr from it.
  - If h_req && (!p_req || starve==STARVE_MAX): grant the FIFO. rf_* take the head, pop, p_hold = p_req.
  - Else if p_req: grant the pipeline. rf_* take p_*, p_hold=0.
  - Else: rf_wr=0.
- Commit:
  - A FIFO grant clears sb[head.addr] at the clock edge.
  - If the same register is set by an issue in the same cycle, set wins. This cannot occur for legal flows because issue stalls on sb[rd]; the rule is still required.
- cred: decrements on every pop, including addr-0 pops. Simultaneous increment and decrement leaves it unchanged.
- starve: increments, saturating, each cycle h_req is true and the FIFO is not granted; resets to 0 on a FIFO grant or when the FIFO is empty.
- FIFO pointers wrap modulo DEPTH; a full/empty distinction bit is required.

Optional Feature:
- Macro: RF_ARB_BYPASS_EN.
- With the macro defined:
  - When the FIFO is empty and !p_req and ll_valid, ll_* is written to the register file in the same cycle and is not pushed.
  - The bypass clears sb and decrements cred exactly like a pop.
  - An ll_addr of 0 is simply consumed.
- Without the macro: every LL result goes through the FIFO, giving a minimum 1-cycle LL-to-register-file latency.

Decomposition:
- Package rf_arb_pkg: REG_W=5, DATA_W=32, NUM_REGS=32, and typedef wb_req_t {addr, data}.
- Sub-module rf_arb_fifo: parameterised DEPTH; push/pop/full/empty/head.
- Arbitration, scoreboard and counters stay in the top level.

Test Plan:
- Issue LL rd=5, then a reader with rs=5 on the next cycle -> iss_stall=1 until an LL result for addr 5 commits (rf_wr=1, rf_addr=5); stall drops the following cycle.
- p_wr to r3 every cycle while an LL result for r7 is queued -> r7 is granted on the 5th cycle (STARVE_MAX=4) with p_hold=1 that cycle; the r3 write lands the next cycle.
- Issue 3 LL instructions with DEPTH=2 -> the third sees iss_stall=1 (cred==2) until the first pop, then is accepted.
- FIFO full and ll_valid=1 -> ll_ready=0, no push, FIFO contents intact; push accepted the cycle after a pop.
- LL result with addr 0 while p_wr writes r9=0xDEADBEEF -> r9 is written, the addr-0 entry pops in the same cycle, cred decrements, p_hold=0.
- Drive reset=0 with 2 entries queued and sb[4]=1 -> the next cycle shows empty FIFO, sb clear, rf_wr=0; a reader of r4 is not stalled after reset is released.
